// File: rtl/temp_poll_ctrl_if.sv
// I2C master request/response bundle between the polling controller and the
// MAX30205 I2C master.
interface temp_poll_ctrl_if;
  logic        i2c_en;
  logic        i2c_wr_rd;
  logic [6:0]  i2c_slave_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_data_wr;
  logic [15:0] i2c_data_rd;
  logic [7:0]  i2c_state;

  modport master (
    output i2c_en,
    output i2c_wr_rd,
    output i2c_slave_addr,
    output i2c_reg_addr,
    output i2c_data_wr,
    input  i2c_data_rd,
    input  i2c_state
  );

  modport slave (
    input  i2c_en,
    input  i2c_wr_rd,
    input  i2c_slave_addr,
    input  i2c_reg_addr,
    input  i2c_data_wr,
    output i2c_data_rd,
    output i2c_state
  );
endinterface

// File: rtl/temp_poll_ctrl.sv
// Periodic MAX30205 temperature poller: launches reads, block-averages samples,
// converts to tenths of a degree and drives a hysteretic fever flag.
module temp_poll_ctrl #(
  parameter int unsigned POLL_CYC    = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter logic [7:0]  TEMP_REG    = 8'h00,
  parameter logic [7:0]  IDLE_STATE  = 8'h00,
  parameter int unsigned FEVER_HI    = 375,
  parameter int unsigned FEVER_LO    = 372
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  temp_poll_ctrl_if.master        bus,
  output logic [15:0]             temp_raw,
  output logic [11:0]             temp_x10,
  output logic                    temp_valid,
  output logic                    fever,
  output logic                    err_timeout,
  output logic [15:0]             sample_cnt
);

  localparam int unsigned PollW = $clog2(POLL_CYC);
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IdxW  = AVG_LOG2 + 1;
  localparam int unsigned AccW  = 16 + AVG_LOG2;

  localparam logic [PollW-1:0] PollLast   = PollW'(POLL_CYC - 1);
  localparam logic [WaitW-1:0] WaitLast   = WaitW'(TIMEOUT_CYC - 1);
  localparam logic [IdxW-1:0]  NumSamples = IdxW'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {
    StIdle, StStart, StWaitBusy, StWaitDone, StCapture, StPublish
  } state_e;

  state_e            state_q, state_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              en_q, en_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       raw_q, raw_d;
  logic [11:0]       x10_q, x10_d;
  logic              valid_q, valid_d;
  logic              fever_q, fever_d;
  logic              to_hit;
  logic [15:0]       avg;
  logic [19:0]       prod;

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    wait_d  = wait_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    en_d    = en_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    x10_d   = x10_q;
    valid_d = 1'b0;
    fever_d = fever_q;
    to_hit  = 1'b0;
    avg     = '0;
    prod    = '0;

    unique case (state_q)
      StIdle: begin
        if (!run) begin
          poll_d = '0;
        end else if (poll_q == PollLast) begin
          poll_d  = '0;
          state_d = StStart;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      StStart: begin
        en_d    = 1'b1;
        wait_d  = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.i2c_state != IDLE_STATE) begin
          en_d    = 1'b0;
          wait_d  = '0;
          state_d = StWaitDone;
        end else if (wait_q == WaitLast) begin
          to_hit = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (bus.i2c_state == IDLE_STATE) begin
          state_d = StCapture;
        end else if (wait_q == WaitLast) begin
          to_hit = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCapture: begin
        acc_d = acc_q + AccW'(bus.i2c_data_rd);
        idx_d = idx_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        err_d = 1'b0;
        if (idx_d == NumSamples) begin
          // Results are registered on this edge so they are visible during PUBLISH.
          avg     = acc_d[AVG_LOG2 +: 16];
          prod    = 20'(avg) * 20'd10 + 20'd128;
          raw_d   = avg;
          x10_d   = avg[15] ? 12'd0 : prod[19:8];
          valid_d = 1'b1;
          if (32'(x10_d) >= FEVER_HI) begin
            fever_d = 1'b1;
          end else if (32'(x10_d) < FEVER_LO) begin
            fever_d = 1'b0;
          end
          state_d = StPublish;
        end else begin
          state_d = StIdle;
        end
      end
      StPublish: begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (to_hit) begin
      err_d   = 1'b1;
      en_d    = 1'b0;
      acc_d   = '0;
      idx_d   = '0;
      wait_d  = '0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      poll_q  <= '0;
      wait_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      raw_q   <= '0;
      x10_q   <= '0;
      valid_q <= 1'b0;
      fever_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      x10_q   <= x10_d;
      valid_q <= valid_d;
      fever_q <= fever_d;
    end
  end

  assign bus.i2c_en         = en_q;
  assign bus.i2c_wr_rd      = 1'b1;
  assign bus.i2c_slave_addr = SLAVE_ADDR;
  assign bus.i2c_reg_addr   = TEMP_REG;
  assign bus.i2c_data_wr    = 8'h00;

  assign temp_raw    = raw_q;
  assign temp_x10    = x10_q;
  assign temp_valid  = valid_q;
  assign fever       = fever_q;
  assign err_timeout = err_q;
  assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Scoreboard bench for temp_poll_ctrl: three instances (AVG_LOG2 = 2, 0, 1)
// each served by a small I2C master model replaying a table of readings.
module tb_temp_poll_ctrl;

  localparam int unsigned NInst = 3;

  typedef struct {
    int          inst;
    logic [15:0] raw;
    logic [11:0] x10;
    logic        fever;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NInst-1:0] run;
  logic [NInst-1:0] bus_hang;
  logic [15:0] rsp_mem [NInst][8];

  wire [15:0] temp_raw   [NInst];
  wire [11:0] temp_x10   [NInst];
  wire [15:0] sample_cnt [NInst];
  wire [NInst-1:0] temp_valid, fever, err_timeout, en, wr_rd;
  wire [6:0] slave_addr [NInst];
  wire [7:0] reg_addr   [NInst];
  wire [7:0] data_wr    [NInst];

  int n_checks = 0;
  int n_fails  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    localparam int unsigned AvgL = (g == 0) ? 2 : ((g == 1) ? 0 : 1);

    temp_poll_ctrl_if u_bus ();

    temp_poll_ctrl #(
      .POLL_CYC    (50),
      .TIMEOUT_CYC (20),
      .AVG_LOG2    (AvgL)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run[g]),
      .bus         (u_bus),
      .temp_raw    (temp_raw[g]),
      .temp_x10    (temp_x10[g]),
      .temp_valid  (temp_valid[g]),
      .fever       (fever[g]),
      .err_timeout (err_timeout[g]),
      .sample_cnt  (sample_cnt[g])
    );

    assign en[g]         = u_bus.i2c_en;
    assign wr_rd[g]      = u_bus.i2c_wr_rd;
    assign slave_addr[g] = u_bus.i2c_slave_addr;
    assign reg_addr[g]   = u_bus.i2c_reg_addr;
    assign data_wr[g]    = u_bus.i2c_data_wr;

    // Master model: goes busy two cycles after a request, idle again six later.
    initial begin : p_bus
      int idx;
      idx = 0;
      u_bus.i2c_state   = 8'h00;
      u_bus.i2c_data_rd = 16'h0000;
      forever begin
        @(negedge clk);
        if (u_bus.i2c_en && !bus_hang[g]) begin
          repeat (2) @(negedge clk);
          u_bus.i2c_state = 8'h05;
          repeat (6) @(negedge clk);
          u_bus.i2c_data_rd = rsp_mem[g][idx];
          u_bus.i2c_state   = 8'h00;
          if (idx < 7) idx++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push(input int inst, input logic [15:0] raw, input logic [11:0] x10,
                      input logic fev, input logic [15:0] cnt);
    exp_t e;
    e.inst  = inst;
    e.raw   = raw;
    e.x10   = x10;
    e.fever = fev;
    e.cnt   = cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_en(input string name, input int inst, input logic lvl, input int budget);
    int n;
    n = 0;
    while (en[inst] !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(en[inst] === lvl), 32'd1);
  endtask

  // Monitor: every published result must match the oldest expected entry.
  initial begin : p_mon
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NInst; i++) begin
        if (temp_valid[i] === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_unexpected_valid: inst %0d raw 0x%0h, expected no publish",
                     i, temp_raw[i]);
          end else begin
            e = exp_q.pop_front();
            check("sb_inst", 32'(i), 32'(e.inst));
            check("sb_temp_raw", 32'(temp_raw[i]), 32'(e.raw));
            check("sb_temp_x10", 32'(temp_x10[i]), 32'(e.x10));
            check("sb_fever", 32'(fever[i]), 32'(e.fever));
            check("sb_sample_cnt", 32'(sample_cnt[i]), 32'(e.cnt));
          end
        end
      end
    end
  end

  initial begin : p_stim
    int n;
    rst_n    = 1'b0;
    run      = '0;
    bus_hang = '0;
    for (int i = 0; i < NInst; i++) begin
      for (int j = 0; j < 8; j++) rsp_mem[i][j] = 16'h0000;
    end
    for (int j = 0; j < 4; j++) rsp_mem[0][j] = 16'h1900;
    rsp_mem[1][0] = 16'h2580;
    rsp_mem[1][1] = 16'h2533;
    rsp_mem[1][2] = 16'h2500;
    rsp_mem[1][3] = 16'hFF00;
    rsp_mem[1][4] = 16'h2580;
    rsp_mem[1][5] = 16'h1234;  // transaction interrupted by reset
    rsp_mem[1][6] = 16'h2400;
    rsp_mem[2][0] = 16'h2400;
    rsp_mem[2][1] = 16'h2600;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NInst; i++) begin
      check("rst_i2c_en", 32'(en[i]), 32'd0);
      check("rst_temp_raw", 32'(temp_raw[i]), 32'd0);
      check("rst_flags", {29'd0, temp_valid[i], fever[i], err_timeout[i]}, 32'd0);
      check("rst_sample_cnt", 32'(sample_cnt[i]), 32'd0);
      check("const_wr_rd", 32'(wr_rd[i]), 32'd1);
      check("const_slave_addr", 32'(slave_addr[i]), 32'h48);
      check("const_reg_addr", 32'(reg_addr[i]), 32'h00);
      check("const_data_wr", 32'(data_wr[i]), 32'h00);
    end
    rst_n = 1'b1;

    // No requests while run is low.
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (en !== '0) n++;
    end
    check("idle_no_en", 32'(n), 32'd0);

    // Four-sample average of 0x1900 -> 25.0 C.
    push(0, 16'h1900, 12'd250, 1'b0, 16'd4);
    run[0] = 1'b1;
    wait_drain("avg4_drain", 800);
    run[0] = 1'b0;

    // Two-sample average of 0x2400/0x2600 -> 0x2500 -> 37.0 C.
    push(2, 16'h2500, 12'd370, 1'b0, 16'd2);
    run[2] = 1'b1;
    wait_drain("avg2_drain", 400);
    run[2] = 1'b0;

    // Unaveraged: fever set at 37.5, held at 37.2, cleared at 37.0; negative clamps to 0.
    push(1, 16'h2580, 12'd375, 1'b1, 16'd1);
    push(1, 16'h2533, 12'd372, 1'b1, 16'd2);
    push(1, 16'h2500, 12'd370, 1'b0, 16'd3);
    push(1, 16'hFF00, 12'd0, 1'b0, 16'd4);
    run[1] = 1'b1;
    wait_drain("avg1_drain", 800);

    // Hung bus: request held exactly TIMEOUT_CYC cycles, then error.
    bus_hang[1] = 1'b1;
    wait_en("to_en_rise", 1, 1'b1, 100);
    n = 0;
    while (en[1] === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("to_en_high_cycles", 32'(n), 32'd20);
    check("to_err_set", 32'(err_timeout[1]), 32'd1);
    check("to_en_dropped", 32'(en[1]), 32'd0);
    bus_hang[1] = 1'b0;
    push(1, 16'h2580, 12'd375, 1'b1, 16'd5);
    wait_drain("recover_drain", 300);
    check("to_err_cleared", 32'(err_timeout[1]), 32'd0);

    // Reset while waiting for the bus to finish: everything clears asynchronously.
    wait_en("rst_en_rise", 1, 1'b1, 100);
    wait_en("rst_en_fall", 1, 1'b0, 20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_i2c_en", 32'(en[1]), 32'd0);
    check("arst_temp_raw", 32'(temp_raw[1]), 32'd0);
    check("arst_temp_x10", 32'(temp_x10[1]), 32'd0);
    check("arst_flags", {29'd0, temp_valid[1], fever[1], err_timeout[1]}, 32'd0);
    check("arst_sample_cnt", 32'(sample_cnt[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Drop run mid-transaction: that sample still publishes, then polling stops.
    push(1, 16'h2400, 12'd360, 1'b0, 16'd1);
    wait_en("stop_en_rise", 1, 1'b1, 120);
    wait_en("stop_en_fall", 1, 1'b0, 20);
    run[1] = 1'b0;
    wait_drain("stop_drain", 100);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (en[1] === 1'b1) n++;
    end
    check("stop_no_en", 32'(n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/temp_poll_ctrl.md
Name: temp_poll_ctrl

Overview:
Polling controller that sits directly upstream of, and consumes the output of, the Temperature I2C master for the MAX30205 body-temperature sensor.
- Every POLL_CYC cycles it launches one register read and waits for the transaction to complete.
- It captures data_rd, block-averages 2^AVG_LOG2 samples and converts the result to tenths of °C.
- It drives a fever flag with hysteresis and detects bus timeouts, for the display/alarm logic downstream.

Parameters:
POLL_CYC, 10_000_000, cycles between transaction launches (100 ms at 100 MHz); minimum 2
TIMEOUT_CYC, 1_000_000, max cycles allowed in each wait state before error
AVG_LOG2, 2, log2 of samples per average (0 = no averaging)
SLAVE_ADDR, 7'h48, MAX30205 address driven to the I2C master
TEMP_REG, 8'h00, temperature register address
IDLE_STATE, 8'h00, value of the I2C master's state output when idle
FEVER_HI, 375, fever set threshold, tenths °C
FEVER_LO, 372, fever clear threshold, tenths °C (FEVER_LO < FEVER_HI)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  polling enable, level
i2c_en  out  1  transaction request to the I2C master
i2c_wr_rd  out  1  constant 1 (read)
i2c_slave_addr  out  7  constant SLAVE_ADDR
i2c_reg_addr  out  8  constant TEMP_REG
i2c_data_wr  out  8  constant 8'h00
i2c_data_rd  in  16  raw temperature from the master, {MSB,LSB}, 1 LSB = 1/256 °C
i2c_state  in  8  master state code
temp_raw  out  16  last published averaged raw value
temp_x10  out  12  last published temperature in tenths °C
temp_valid  out  1  one-cycle pulse when temp_raw/temp_x10 update
fever  out  1  fever flag with hysteresis
err_timeout  out  1  sticky timeout flag
sample_cnt  out  16  count of good samples captured, wraps at 16'hFFFF->0

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0 except the constant I2C outputs;
  - FSM enters IDLE, poll counter = 0, accumulator and sample counter cleared.
  - Reset mid-transaction drops i2c_en immediately; no sample is published.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, CAPTURE, PUBLISH.
- IDLE:
  - poll counter increments while run=1 and holds at 0 while run=0.
  - When it reaches POLL_CYC-1: clear the counter, go to START.
- START: i2c_en=1 registered; go to WAIT_BUSY.
- WAIT_BUSY:
  - hold i2c_en=1 until i2c_state != IDLE_STATE;
  - on that cycle drop i2c_en to 0 and go to WAIT_DONE.
- WAIT_DONE: when i2c_state == IDLE_STATE, go to CAPTURE.
- Timeout, in WAIT_BUSY or WAIT_DONE:
  - a wait counter counts cycles in each wait state separately, restarting at 0 on entry.
  - At TIMEOUT_CYC: set err_timeout=1, i2c_en=0, clear the accumulator and sample index, return to IDLE.
- CAPTURE (one cycle):
  - accumulator (16+AVG_LOG2 bits, unsigned) += i2c_data_rd; sample index++; sample_cnt++; err_timeout cleared.
  - If sample index reaches 2^AVG_LOG2, go to PUBLISH; else go to IDLE.
- PUBLISH (one cycle):
  - avg = accumulator >> AVG_LOG2.
  - temp_raw=avg.
  - If avg[15]=1 (negative), temp_x10=0; else temp_x10 = (avg*10 + 128) >> 8, computed in 20 bits, truncated to 12.
  - temp_valid=1 for this cycle only.
  - Clear the accumulator and index; return to IDLE.
- Fever, updated in PUBLISH only, using the new temp_x10:
  - set if temp_x10 >= FEVER_HI;
  - clear if temp_x10 < FEVER_LO;
  - otherwise hold.
- Outputs are registered; temp_raw/temp_x10 appear one cycle after CAPTURE of the final sample.
- run deasserted mid-transaction: the current transaction completes normally (including CAPTURE/PUBLISH), then the FSM stays in IDLE.
- The poll interval is measured IDLE-to-IDLE; transaction time adds to it. No overlapping requests.
- The I2C master reports no NACK; a hung or NACKed transaction is caught only by the timeout.

Test Plan:
1. AVG_LOG2=2, POLL_CYC=50, bus model returns 16'h1900 for 4 reads -> one temp_valid pulse after the 4th read; temp_raw=16'h1900, temp_x10=250, fever=0, sample_cnt=4.
2. AVG_LOG2=0, sequence 16'h2580, 16'h2533, 16'h2500 -> temp_x10 = 375, 372, 370; fever 1, 1, 0.
3. AVG_LOG2=1, reads 16'h2400 and 16'h2600 -> temp_raw=16'h2500, temp_x10=370.
4. AVG_LOG2=0, read 16'hFF00 -> temp_raw=16'hFF00, temp_x10=0, fever unchanged.
5. i2c_state held at IDLE_STATE, TIMEOUT_CYC=20 -> i2c_en high exactly 20 cycles after START, then err_timeout=1 and i2c_en=0. The next good read clears err_timeout and publishes normally.
6. rst_n pulsed low during WAIT_DONE -> i2c_en=0 and all outputs 0 asynchronously; no temp_valid. Drop run during WAIT_DONE -> that sample publishes, then no further i2c_en pulses.
